// File: rtl/ap_ctrl_hs_driver_if.sv
// Command, ap_ctrl_hs handshake and run-statistics signals between host, driver and HLS core.
// master = the driver side, slave = the host/core side.
interface ap_ctrl_hs_driver_if #(
  parameter int ITER_W = 16,
  parameter int LAT_W  = 32
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ITER_W-1:0] cmd_count;
  logic              abort;
  logic              ap_start;
  logic              ap_ready;
  logic              ap_done;
  logic              busy;
  logic              run_done;
  logic              timeout_err;
  logic [ITER_W-1:0] iter_cnt;
  logic [LAT_W-1:0]  last_latency;
  logic [LAT_W-1:0]  max_latency;
  logic [LAT_W-1:0]  run_cycles;

  modport master (
    input  cmd_valid, cmd_count, abort, ap_ready, ap_done,
    output cmd_ready, ap_start, busy, run_done, timeout_err,
           iter_cnt, last_latency, max_latency, run_cycles
  );

  modport slave (
    output cmd_valid, cmd_count, abort, ap_ready, ap_done,
    input  cmd_ready, ap_start, busy, run_done, timeout_err,
           iter_cnt, last_latency, max_latency, run_cycles
  );
endinterface

// File: rtl/ap_ctrl_hs_driver.sv
// ap_ctrl_hs initiator: runs cmd_count back-to-back core transactions, one outstanding, registered outputs.
// Commands accepted only in IDLE (cmd_ready); core backpressure via ap_ready, hangs bounded by TIMEOUT.
module ap_ctrl_hs_driver #(
  parameter int ITER_W  = 16,
  parameter int LAT_W   = 32,
  parameter int TIMEOUT = 4096
) (
  input logic                 clock,
  input logic                 reset,
  ap_ctrl_hs_driver_if.master bus
);

  typedef enum logic [1:0] {IDLE, START, WAIT_DONE, FINISH} state_t;

  localparam logic [LAT_W-1:0] LAT_MAX = '1;
  localparam logic [63:0]      TMO     = 64'(TIMEOUT);

  state_t            state, state_nxt;
  logic [ITER_W-1:0] remaining;
  logic [LAT_W-1:0]  lat;
  logic              accept;
  logic              in_txn;
  logic              complete;
  logic              tmo_hit;

  always_comb begin
    accept    = 1'b0;
    in_txn    = 1'b0;
    complete  = 1'b0;
    tmo_hit   = 1'b0;
    state_nxt = state;

    accept = (state == IDLE) && bus.cmd_valid;
    in_txn = (state == START) || (state == WAIT_DONE);
    // ap_done without ap_ready while still starting is a core protocol violation and is ignored
    complete = ((state == START) && bus.ap_ready && bus.ap_done) ||
               ((state == WAIT_DONE) && bus.ap_done);
    tmo_hit  = (TIMEOUT != 0) && in_txn && !complete && (64'(lat) == TMO);

    case (state)
      IDLE: begin
        if (accept) state_nxt = (bus.cmd_count == '0) ? FINISH : START;
      end
      START, WAIT_DONE: begin
        if (complete)
          state_nxt = ((remaining == ITER_W'(1)) || bus.abort) ? FINISH : START;
        else if (tmo_hit || bus.abort)
          state_nxt = FINISH;
        else if ((state == START) && bus.ap_ready)
          state_nxt = WAIT_DONE;
      end
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      remaining        <= '0;
      lat              <= '0;
      bus.ap_start     <= 1'b0;
      bus.cmd_ready    <= 1'b1;
      bus.busy         <= 1'b0;
      bus.run_done     <= 1'b0;
      bus.timeout_err  <= 1'b0;
      bus.iter_cnt     <= '0;
      bus.last_latency <= '0;
      bus.max_latency  <= '0;
      bus.run_cycles   <= '0;
    end else begin
      state         <= state_nxt;
      bus.ap_start  <= (state_nxt == START);
      bus.cmd_ready <= (state_nxt == IDLE);
      bus.busy      <= (state_nxt != IDLE);
      bus.run_done  <= (state_nxt == FINISH);

      if (accept) begin
        remaining        <= bus.cmd_count;
        bus.iter_cnt     <= '0;
        bus.last_latency <= '0;
        bus.max_latency  <= '0;
        bus.run_cycles   <= '0;
        bus.timeout_err  <= 1'b0;
      end else begin
        if ((state != IDLE) && (bus.run_cycles != LAT_MAX))
          bus.run_cycles <= bus.run_cycles + LAT_W'(1);
        if (complete) begin
          bus.iter_cnt     <= bus.iter_cnt + ITER_W'(1);
          remaining        <= remaining - ITER_W'(1);
          bus.last_latency <= lat;
          if (lat > bus.max_latency) bus.max_latency <= lat;
        end
        if (tmo_hit) bus.timeout_err <= 1'b1;
      end

      // lat reads 1 in the first START cycle of every transaction, including zero-bubble restarts
      if (accept || complete)
        lat <= LAT_W'(1);
      else if (in_txn && (lat != LAT_MAX))
        lat <= lat + LAT_W'(1);
    end
  end

endmodule
